// File: rtl/i2s_pkg.sv
// i2s_pkg: default link parameters and slot/bit-position decode helpers shared
// by the I2S transceiver and its TX FIFO.
package i2s_pkg;

   localparam int SAMPLE_WIDTH_DEF = 24;
   localparam int SLOT_WIDTH_DEF   = 32;
   localparam int BCLK_DIV_DEF     = 4;
   localparam int FIFO_DEPTH_DEF   = 4;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int slot_pos(input int b, input int slot_width);
      return b % slot_width;
   endfunction

   // Position 0 of each slot is the one-BCLK I2S delay; data follows MSB first.
   function automatic logic is_data_pos(input int pos, input int sample_width);
      return pos >= 1 && pos <= sample_width;
   endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: synchronous FIFO holding stereo pairs for the I2S transmitter.
// Ports: clk_i/rst_i (async active-high), push_i/data_i write side (ignored when
// full), pop_i/data_o read side (ignored when empty, data_o shows the head),
// full_o/empty_o flags, level_o occupancy.
module i2s_tx_fifo import i2s_pkg::*; #(
   parameter int WIDTH = 2 * SAMPLE_WIDTH_DEF,
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  push_i,
   input  logic [WIDTH-1:0]      data_i,
   input  logic                  pop_i,
   output logic [WIDTH-1:0]      data_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [clog2(DEPTH):0] level_o
);

   localparam int AW = clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [LW-1:0]    level_q;
   logic             push, pop;

   assign full_o  = level_q == LW'(DEPTH);
   assign empty_o = level_q == '0;
   assign push    = push_i && !full_o;
   assign pop     = pop_i && !empty_o;
   assign data_o  = mem_q[rd_q];
   assign level_o = level_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         wr_q    <= wr_q + AW'(push);
         rd_q    <= rd_q + AW'(pop);
         level_q <= level_q + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/i2s_codec_serdes.sv
// i2s_codec_serdes: I2S master transceiver for the ADAU1761 codec.
// Ports: DATA_CLK_I clock, RESET async active-high; enable runs the link;
// tx_left/tx_right/tx_valid/tx_ready push stereo pairs into the TX FIFO
// (tx_level occupancy, tx_underflow pulses when a frame starts with it empty);
// rx_left/rx_right/rx_valid publish each received pair; BCLK_O, LRCLK_O,
// SDATA_O drive the codec and SDATA_I returns its data.
module i2s_codec_serdes import i2s_pkg::*; #(
   parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
   parameter int SLOT_WIDTH   = SLOT_WIDTH_DEF,
   parameter int BCLK_DIV     = BCLK_DIV_DEF,
   parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
   input  logic                       DATA_CLK_I,
   input  logic                       RESET,
   input  logic                       enable,
   input  logic [SAMPLE_WIDTH-1:0]    tx_left,
   input  logic [SAMPLE_WIDTH-1:0]    tx_right,
   input  logic                       tx_valid,
   output logic                       tx_ready,
   output logic [clog2(FIFO_DEPTH):0] tx_level,
   output logic                       tx_underflow,
   output logic [SAMPLE_WIDTH-1:0]    rx_left,
   output logic [SAMPLE_WIDTH-1:0]    rx_right,
   output logic                       rx_valid,
   output logic                       BCLK_O,
   output logic                       LRCLK_O,
   output logic                       SDATA_O,
   input  logic                       SDATA_I
);

   localparam int SW    = SAMPLE_WIDTH;
   localparam int FRAME = 2 * SLOT_WIDTH;
   localparam int DW    = clog2(BCLK_DIV);
   localparam int BW    = clog2(FRAME);
   localparam int IW    = clog2(SW);

   logic [DW-1:0]   div_q, div_d;
   logic [BW-1:0]   bit_q, bit_d;
   logic            first_q, first_d;
   logic            bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
   logic            uf_q, uf_d, rxv_q, rxv_d;
   logic [2*SW-1:0] hold_q, hold_d, fifo_rd;
   logic [SW-1:0]   rxl_sh_q, rxl_sh_d, rxr_sh_q, rxr_sh_d;
   logic [SW-1:0]   rx_left_q, rx_left_d, rx_right_q, rx_right_d;
   logic [SW-1:0]   tx_word;
   logic [IW-1:0]   tx_idx;
   logic            fall, frame_start, fifo_empty, fifo_full, tx_lr, rx_sample, rx_done;
   int              tx_pos, rx_pos;

   i2s_tx_fifo #(.WIDTH(2 * SW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (DATA_CLK_I),
      .rst_i   (RESET),
      .push_i  (tx_valid),
      .data_i  ({tx_left, tx_right}),
      .pop_i   (frame_start),
      .data_o  (fifo_rd),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (tx_level)
   );

   // TX decode works on the next bit position and next holding word so the
   // first frame after enable (popped at its first falling event) drives its
   // MSB in the same event.
   always_comb begin
      fall        = enable && div_q == DW'(BCLK_DIV - 1);
      frame_start = fall && (first_q || bit_q == BW'(FRAME - 1));
      div_d       = (!enable || fall) ? '0 : div_q + 1'b1;
      bit_d       = !enable ? '0 : !fall ? bit_q : bit_q == BW'(FRAME - 1) ? '0 : bit_q + 1'b1;
      first_d     = !enable ? 1'b1 : fall ? 1'b0 : first_q;
      hold_d      = !frame_start ? hold_q : fifo_empty ? '0 : fifo_rd;
      tx_pos      = slot_pos(int'(bit_d), SLOT_WIDTH);
      tx_lr       = bit_d >= BW'(SLOT_WIDTH);
      tx_word     = tx_lr ? hold_d[SW-1:0] : hold_d[2*SW-1:SW];
      tx_idx      = IW'(SW - tx_pos);
      sdata_d     = !enable ? 1'b0 : !fall ? sdata_q : is_data_pos(tx_pos, SW) && tx_word[tx_idx];
      bclk_d      = enable && div_d >= DW'(BCLK_DIV / 2);
      lrclk_d     = enable && tx_lr;
      uf_d        = frame_start && fifo_empty;
      rx_pos      = slot_pos(int'(bit_q), SLOT_WIDTH);
      rx_sample   = fall && is_data_pos(rx_pos, SW);
      rx_done     = fall && bit_q == BW'(SLOT_WIDTH + SW);
      rxl_sh_d    = !enable ? '0 : rx_sample && !lrclk_q ? {rxl_sh_q[SW-2:0], SDATA_I} : rxl_sh_q;
      rxr_sh_d    = !enable ? '0 : rx_sample && lrclk_q ? {rxr_sh_q[SW-2:0], SDATA_I} : rxr_sh_q;
      rx_left_d   = rx_done ? rxl_sh_q : rx_left_q;
      rx_right_d  = rx_done ? rxr_sh_d : rx_right_q;
      rxv_d       = rx_done;
   end

   always_ff @(posedge DATA_CLK_I or posedge RESET) begin
      if (RESET) begin
         div_q      <= '0;
         bit_q      <= '0;
         first_q    <= 1'b1;
         bclk_q     <= 1'b0;
         lrclk_q    <= 1'b0;
         sdata_q    <= 1'b0;
         uf_q       <= 1'b0;
         rxv_q      <= 1'b0;
         hold_q     <= '0;
         rxl_sh_q   <= '0;
         rxr_sh_q   <= '0;
         rx_left_q  <= '0;
         rx_right_q <= '0;
      end else begin
         div_q      <= div_d;
         bit_q      <= bit_d;
         first_q    <= first_d;
         bclk_q     <= bclk_d;
         lrclk_q    <= lrclk_d;
         sdata_q    <= sdata_d;
         uf_q       <= uf_d;
         rxv_q      <= rxv_d;
         hold_q     <= hold_d;
         rxl_sh_q   <= rxl_sh_d;
         rxr_sh_q   <= rxr_sh_d;
         rx_left_q  <= rx_left_d;
         rx_right_q <= rx_right_d;
      end
   end

   assign tx_ready     = !fifo_full;
   assign tx_underflow = uf_q;
   assign rx_left      = rx_left_q;
   assign rx_right     = rx_right_q;
   assign rx_valid     = rxv_q;
   assign BCLK_O       = bclk_q;
   assign LRCLK_O      = lrclk_q;
   assign SDATA_O      = sdata_q;

endmodule

// File: tb/tb_i2s_codec_serdes.sv
// tb_i2s_codec_serdes: scoreboard bench with a phase-arithmetic reference model,
// SDATA_O looped back to SDATA_I.
module tb_i2s_codec_serdes;

   localparam int SW    = 24;
   localparam int SLOT  = 32;
   localparam int BD    = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 2 * SLOT;

   logic          clk = 1'b0;
   logic          rst, enable, tx_valid, tx_ready, tx_underflow, rx_valid;
   logic          bclk, lrclk, sdo;
   logic [SW-1:0] tx_left, tx_right, rx_left, rx_right;
   logic [2:0]    tx_level;

   int checks = 0;
   int errors = 0;

   int          ph;
   logic [47:0] hold;
   logic [47:0] mfifo[$];
   logic [47:0] rx_exp[$];
   logic        e_bclk, e_lr, e_sd, e_uf, e_rv;

   i2s_codec_serdes dut (
      .DATA_CLK_I   (clk),
      .RESET        (rst),
      .enable       (enable),
      .tx_left      (tx_left),
      .tx_right     (tx_right),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .tx_level     (tx_level),
      .tx_underflow (tx_underflow),
      .rx_left      (rx_left),
      .rx_right     (rx_right),
      .rx_valid     (rx_valid),
      .BCLK_O       (bclk),
      .LRCLK_O      (lrclk),
      .SDATA_O      (sdo),
      .SDATA_I      (sdo)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: ph counts enabled clocks; every BD-th is a falling event,
   // the falling-event count gives the frame bit; pairs leave the FIFO at frame
   // starts and come back through the loopback in the same frame.
   initial begin
      int          f, bitn, pos;
      logic        push_ok;
      logic [47:0] sh;
      ph = 0; hold = '0;
      e_bclk = 0; e_lr = 0; e_sd = 0; e_uf = 0; e_rv = 0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            ph = 0; hold = '0;
            mfifo.delete(); rx_exp.delete();
            e_bclk = 0; e_lr = 0; e_sd = 0; e_uf = 0; e_rv = 0;
         end else begin
            push_ok = tx_valid && mfifo.size() < DEPTH;
            e_uf = 0;
            e_rv = 0;
            if (!enable) begin
               ph = 0; e_bclk = 0; e_lr = 0; e_sd = 0;
               rx_exp.delete();
            end else begin
               ph++;
               f = ph / BD;
               bitn = f % FRAME;
               if (ph % BD == 0 && (f == 1 || bitn == 0)) begin
                  if (mfifo.size() > 0) hold = mfifo.pop_front();
                  else begin
                     hold = '0;
                     e_uf = 1;
                  end
                  rx_exp.push_back(hold);
               end
               e_rv = ph % BD == 0 && bitn == SLOT + SW + 1;
               e_bclk = ph % BD >= BD / 2;
               e_lr = bitn >= SLOT;
               pos = bitn % SLOT;
               sh = hold >> (e_lr ? SW - pos : 2 * SW - pos);
               e_sd = pos >= 1 && pos <= SW && sh[0];
            end
            if (push_ok) mfifo.push_back({tx_left, tx_right});
         end
      end
   end

   // Monitor: pins and flags every cycle; RX pairs popped from the scoreboard.
   initial forever begin
      @(negedge clk);
      chk("bclk", bclk, e_bclk);
      chk("lrclk", lrclk, e_lr);
      chk("sdata", sdo, e_sd);
      chk("underflow", tx_underflow, e_uf);
      chk("rx_valid", rx_valid, e_rv);
      chk("level", tx_level, mfifo.size());
      chk("ready", tx_ready, mfifo.size() < DEPTH);
      if (rx_valid) begin
         chk("rx_expected_pending", rx_exp.size() > 0, 1);
         if (rx_exp.size() > 0) chk("rx_pair", {rx_left, rx_right}, rx_exp.pop_front());
      end
   end

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
      tx_left = l;
      tx_right = r;
      tx_valid = 1;
      run(1);
      tx_valid = 0;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_bclk"}, bclk, 0);
      chk({tag, "_lrclk"}, lrclk, 0);
      chk({tag, "_sdata"}, sdo, 0);
      chk({tag, "_rx_valid"}, rx_valid, 0);
      chk({tag, "_rx_left"}, rx_left, 0);
      chk({tag, "_rx_right"}, rx_right, 0);
      chk({tag, "_underflow"}, tx_underflow, 0);
      chk({tag, "_level"}, tx_level, 0);
      chk({tag, "_ready"}, tx_ready, 1);
   endtask

   initial begin
      int   r1, r2, lvl, budget;
      logic prev;
      rst = 1; enable = 0; tx_valid = 0; tx_left = '0; tx_right = '0;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      rst = 0;
      run(2);
      push_pair(24'hA5A5A5, 24'h3C3C3C);
      enable = 1;
      r1 = -1; r2 = -1; prev = 0;
      for (int i = 0; i < 40 && r2 < 0; i++) begin
         @(negedge clk);
         if (bclk && !prev) begin
            if (r1 < 0) r1 = i;
            else r2 = i;
         end
         prev = bclk;
      end
      chk("bclk_period", r2 - r1, BD);
      @(posedge clk);
      #1;
      run(600);
      rst = 1;
      #1;
      check_idle("midframe_reset");
      enable = 0;
      run(1);
      rst = 0;
      run(2);
      enable = 1;
      run(600);
      push_pair(24'($urandom), 24'($urandom));
      run(800);
      enable = 0;
      run(2);
      for (int i = 0; i < 5; i++) begin
         tx_left = 24'($urandom);
         tx_right = 24'($urandom);
         tx_valid = 1;
         run(1);
      end
      tx_valid = 0;
      chk("full_ready", tx_ready, 0);
      chk("full_level", tx_level, 4);
      enable = 1;
      for (int i = 0; i < 700; i++) begin
         tx_left = 24'($urandom);
         tx_right = 24'($urandom);
         tx_valid = 1;
         run(1);
      end
      tx_valid = 0;
      run(1200);
      for (int i = 0; i < 8; i++) begin
         push_pair(24'($urandom), 24'($urandom));
         run(250 + $urandom_range(0, 50));
      end
      run(600);
      for (int i = 0; i < 3; i++) push_pair(24'($urandom), 24'($urandom));
      budget = 0;
      while (((ph / BD) % FRAME != 40 || ph % BD != 0) && budget < 600) begin
         run(1);
         budget++;
      end
      chk("reached_bit40", (ph / BD) % FRAME, 40);
      lvl = mfifo.size();
      enable = 0;
      run(1);
      chk("disable_bclk", bclk, 0);
      chk("disable_lrclk", lrclk, 0);
      chk("disable_sdata", sdo, 0);
      chk("disable_level_kept", tx_level, lvl);
      run(100);
      enable = 1;
      run(700);
      enable = 0;
      run(4);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
